// File: rtl/ram_test_ctrl_if.sv
// Memory request/response bus between the RAM test controller and the memory interface controller.
interface ram_test_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              mem_rdy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  mem_rdy, mem_rvalid, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output mem_rdy, mem_rvalid, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ram_test_ctrl.sv
// Button/switch-driven RAM test controller: manual lane-assembled write/readback and
// seeded auto-pattern sweep with mismatch counting.

module ram_test_ctrl_deb #(
    parameter int TAPS = 4
) (
    input  logic clk,
    input  logic sys_rst_n,
    input  logic tick,
    input  logic raw,
    output logic pulse
);
    logic [1:0]      sync_q;
    logic [TAPS-1:0] sr_q;
    logic            lvl_q;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
            sr_q   <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (tick)
                sr_q <= {sr_q[TAPS-2:0], sync_q[1]};
            lvl_q  <= &sr_q;
        end
    end

    // Level only moves on tick cycles, so this is high for exactly one clk per press.
    assign pulse = (&sr_q) & ~lvl_q;
endmodule

module ram_test_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 16,
    parameter int SW_W     = 8,
    parameter int DEB_DIV  = 11,
    parameter int DEB_TAPS = 4,
    parameter int AUTO_LEN = 256
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic [SW_W-1:0]   sw,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_sel,
    input  logic              mode,
    ram_test_ctrl_if.master   mem,
    output logic [DATA_W-1:0] disp_data,
    output logic [15:0]       err_cnt,
    output logic              done,
    output logic [2:0]        state_dbg
);
    localparam int NL     = DATA_W / SW_W;
    localparam int LANE_W = (NL > 1) ? $clog2(NL) : 1;
    localparam int CNT_W  = $clog2(AUTO_LEN) + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NL - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(AUTO_LEN - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0, WR = 3'd1, RD = 3'd2, RWAIT = 3'd3,
        A_WR = 3'd4, A_RD = 3'd5, A_RWAIT = 3'd6, DONE = 3'd7
    } state_t;

    state_t                    state, state_n;
    logic [ADDR_W-1:0]         addr_q, addr_n;
    logic [NL-1:0][SW_W-1:0]   wdata_q, wdata_n;
    logic [LANE_W-1:0]         lane_q, lane_n;
    logic [SW_W-1:0]           seed_q, seed_n;
    logic [CNT_W-1:0]          cnt_q, cnt_n;
    logic [15:0]               err_q, err_n;
    logic [DATA_W-1:0]         disp_q, disp_n;
    logic                      req, we;

    // Debounce sample strobe: a clock enable, everything stays on clk.
    logic [DEB_DIV-1:0] div_q;
    logic               tick;
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) div_q <= '0;
        else            div_q <= div_q + DEB_DIV'(1);
    end
    assign tick = &div_q;

    logic [2:0] raw, pulse;
    logic       up_p, dn_p, sel_p;
    assign raw = {btn_sel, btn_dn, btn_up};

    for (genvar i = 0; i < 3; i++) begin : g_deb
        ram_test_ctrl_deb #(.TAPS(DEB_TAPS)) u_deb (
            .clk       (clk),
            .sys_rst_n (sys_rst_n),
            .tick      (tick),
            .raw       (raw[i]),
            .pulse     (pulse[i])
        );
    end
    assign {sel_p, dn_p, up_p} = pulse;

    logic [DATA_W-1:0] addr_ext, pat;
    if (ADDR_W >= DATA_W) begin : g_trunc
        assign addr_ext = addr_q[DATA_W-1:0];
    end else begin : g_zext
        assign addr_ext = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
    end
    assign pat = {NL{seed_q}} ^ addr_ext;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            lane_q  <= '0;
            seed_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            disp_q  <= '0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            lane_q  <= lane_n;
            seed_q  <= seed_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            disp_q  <= disp_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        lane_n  = lane_q;
        seed_n  = seed_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        disp_n  = disp_q;
        req     = 1'b0;
        we      = 1'b0;
        case (state)
            IDLE: begin
                if (sel_p) begin
                    if (lane_q == '0 && mode) begin
                        seed_n  = sw;
                        err_n   = '0;
                        cnt_n   = '0;
                        state_n = A_WR;
                    end else begin
                        wdata_n[lane_q] = sw;
                        if (lane_q == LAST_LANE) begin
                            lane_n  = '0;
                            state_n = WR;
                        end else begin
                            lane_n = lane_q + LANE_W'(1);
                        end
                    end
                end else if (lane_q == '0 && up_p && !dn_p) begin
                    addr_n = addr_q + ADDR_W'(1);
                end else if (lane_q == '0 && dn_p && !up_p) begin
                    addr_n = addr_q - ADDR_W'(1);
                end
            end
            WR: if (mem.mem_rdy) begin
                req     = 1'b1;
                we      = 1'b1;
                state_n = RD;
            end
            RD: if (mem.mem_rdy) begin
                req     = 1'b1;
                state_n = RWAIT;
            end
            RWAIT: if (mem.mem_rvalid) begin
                disp_n = mem.mem_rdata;
                if (mem.mem_rdata != wdata_q && err_q != 16'hFFFF)
                    err_n = err_q + 16'd1;
                state_n = IDLE;
            end
            A_WR: if (mem.mem_rdy) begin
                req = 1'b1;
                we  = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Rewind to the run's start address for the readback pass.
                    addr_n  = addr_q + ADDR_W'(1) - ADDR_W'(AUTO_LEN);
                    cnt_n   = '0;
                    state_n = A_RD;
                end else begin
                    addr_n = addr_q + ADDR_W'(1);
                    cnt_n  = cnt_q + CNT_W'(1);
                end
            end
            A_RD: if (mem.mem_rdy) begin
                req     = 1'b1;
                state_n = A_RWAIT;
            end
            A_RWAIT: if (mem.mem_rvalid) begin
                disp_n = mem.mem_rdata;
                if (mem.mem_rdata != pat && err_q != 16'hFFFF)
                    err_n = err_q + 16'd1;
                addr_n = addr_q + ADDR_W'(1);
                if (cnt_q == LAST_CNT) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n   = cnt_q + CNT_W'(1);
                    state_n = A_RD;
                end
            end
            DONE: if (sel_p) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = (state == A_WR) ? pat : wdata_q;
    assign disp_data     = disp_q;
    assign err_cnt       = err_q;
    assign done          = (state == DONE);
    assign state_dbg     = state;
endmodule

// File: tb/tb_ram_test_ctrl.sv
// Directed bench for ram_test_ctrl with a 2-cycle-latency memory model.
module tb_ram_test_ctrl;
    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  sw = '0;
    logic        btn_up = 1'b0, btn_dn = 1'b0, btn_sel = 1'b0, mode = 1'b0;
    logic [15:0] disp_data, err_cnt;
    logic        done;
    logic [2:0]  state_dbg;
    logic        rdy_en = 1'b1, corrupt = 1'b0;
    int          n_chk = 0, n_err = 0;

    ram_test_ctrl_if #(.ADDR_W(32), .DATA_W(16)) m();

    ram_test_ctrl #(
        .ADDR_W(32), .DATA_W(16), .SW_W(8),
        .DEB_DIV(2), .DEB_TAPS(4), .AUTO_LEN(4)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .sw        (sw),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .btn_sel   (btn_sel),
        .mode      (mode),
        .mem       (m),
        .disp_data (disp_data),
        .err_cnt   (err_cnt),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;
    assign m.mem_rdy = rdy_en;

    // Memory model: reads return data two cycles after the request.
    logic [15:0] mem_arr [64];
    int          wr_n = 0, rd_n = 0, viol = 0;
    logic [31:0] wr_a = '0, rd_a = '0;
    logic [15:0] wr_d = '0;
    logic        p1_v = 1'b0;
    logic [15:0] p1_d = '0;

    always @(posedge clk) begin
        m.mem_rvalid <= p1_v;
        m.mem_rdata  <= p1_d;
        p1_v         <= 1'b0;
        if (m.mem_req) begin
            if (!m.mem_rdy) viol <= viol + 1;
            if (m.mem_we) begin
                mem_arr[m.mem_addr[5:0]] <= m.mem_wdata;
                wr_n <= wr_n + 1;
                wr_a <= m.mem_addr;
                wr_d <= m.mem_wdata;
            end else begin
                p1_v <= 1'b1;
                p1_d <= mem_arr[m.mem_addr[5:0]] ^ (corrupt ? 16'hFFFF : 16'h0000);
                rd_n <= rd_n + 1;
                rd_a <= m.mem_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b, input int hold);
        case (b)
            0: btn_up = 1'b1;
            1: btn_dn = 1'b1;
            default: btn_sel = 1'b1;
        endcase
        cyc(hold);
        btn_up = 1'b0; btn_dn = 1'b0; btn_sel = 1'b0;
        cyc(40);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int k = 0;
        while (state_dbg !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, state_dbg, s);
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, " req"},   m.mem_req, 0);
        chk({tag, " we"},    m.mem_we, 0);
        chk({tag, " addr"},  m.mem_addr, 0);
        chk({tag, " wdata"}, m.mem_wdata, 0);
        chk({tag, " disp"},  disp_data, 0);
        chk({tag, " err"},   err_cnt, 0);
        chk({tag, " done"},  done, 0);
        chk({tag, " state"}, state_dbg, 0);
    endtask

    initial begin
        int w0, r0;
        cyc(5);
        outputs_zero("reset");
        sys_rst_n = 1'b1;
        cyc(5);

        // Address buttons
        repeat (3) press(0, 40);
        press(1, 40);
        chk("addr up3 dn1", m.mem_addr, 32'd2);
        repeat (2) press(1, 40);
        repeat (3) press(1, 40);
        chk("addr wrap dn3", m.mem_addr, 32'hFFFF_FFFD);
        repeat (3) press(0, 40);
        chk("addr wrap back", m.mem_addr, 32'd0);

        // Debounce: 3-tick glitch ignored, long hold gives one step
        press(0, 12);
        chk("glitch", m.mem_addr, 32'd0);
        press(0, 400);
        chk("long hold", m.mem_addr, 32'd1);

        // Manual write/readback at address 5
        repeat (4) press(0, 40);
        chk("addr 5", m.mem_addr, 32'd5);
        w0 = wr_n; r0 = rd_n;
        sw = 8'h34; press(2, 40);
        chk("lane1 state", state_dbg, 3'd0);
        sw = 8'h12; press(2, 40);
        wait_state("man idle", 3'd0, 200);
        chk("man wr count", wr_n - w0, 1);
        chk("man wr addr", wr_a, 32'd5);
        chk("man wr data", wr_d, 16'h1234);
        chk("man rd count", rd_n - r0, 1);
        chk("man rd addr", rd_a, 32'd5);
        chk("man disp", disp_data, 16'h1234);
        chk("man err", err_cnt, 16'd0);

        // Corrupted readback
        corrupt = 1'b1;
        sw = 8'h34; press(2, 40);
        sw = 8'h12; press(2, 40);
        wait_state("bad idle", 3'd0, 200);
        chk("bad disp", disp_data, 16'hEDCB);
        chk("bad err", err_cnt, 16'd1);
        corrupt = 1'b0;

        // Auto run from address 8, seed A5
        repeat (3) press(0, 40);
        chk("addr 8", m.mem_addr, 32'd8);
        w0 = wr_n; r0 = rd_n;
        mode = 1'b1; sw = 8'hA5;
        press(2, 40);
        wait_state("auto done state", 3'd7, 400);
        mode = 1'b0;
        chk("auto wr count", wr_n - w0, 4);
        chk("auto rd count", rd_n - r0, 4);
        chk("auto m8",  mem_arr[8],  16'hA5AD);
        chk("auto m9",  mem_arr[9],  16'hA5AC);
        chk("auto m10", mem_arr[10], 16'hA5AF);
        chk("auto m11", mem_arr[11], 16'hA5AE);
        chk("auto err", err_cnt, 16'd0);
        chk("auto done", done, 1'b1);
        chk("auto addr", m.mem_addr, 32'd12);
        chk("auto disp", disp_data, 16'hA5AE);
        press(2, 40);
        chk("done ack state", state_dbg, 3'd0);
        chk("done ack flag", done, 1'b0);

        // Stalled memory in WR
        rdy_en = 1'b0;
        w0 = wr_n;
        sw = 8'hCD; press(2, 40);
        sw = 8'hAB; press(2, 40);
        chk("stall state", state_dbg, 3'd1);
        chk("stall req", m.mem_req, 1'b0);
        cyc(10);
        chk("stall no write", wr_n - w0, 0);
        rdy_en = 1'b1;
        wait_state("stall resume", 3'd0, 200);
        chk("stall wr addr", wr_a, 32'd12);
        chk("stall wr data", wr_d, 16'hABCD);
        chk("stall err", err_cnt, 16'd0);
        chk("no req w/o rdy", viol, 0);

        // Reset during auto write
        rdy_en = 1'b0;
        mode = 1'b1; sw = 8'h3C;
        press(2, 40);
        chk("mid A_WR", state_dbg, 3'd4);
        sys_rst_n = 1'b0;
        cyc(1);
        outputs_zero("mid reset");
        mode = 1'b0; rdy_en = 1'b1;
        w0 = wr_n;
        cyc(2);
        sys_rst_n = 1'b1;
        cyc(20);
        chk("post reset idle", state_dbg, 3'd0);
        chk("post reset no wr", wr_n - w0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
